dmem_mshr_ctrl: RTL and testbench

//  Parametrised successor to the single-miss D-cache memory controller: arbitrates dcache writebacks,

---
 rtl/dmem_mshr_ctrl_pkg.sv | 31 +++
 rtl/dmem_mshr_ctrl_free_sel.sv | 26 ++
 rtl/dmem_mshr_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmem_mshr_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mshr_ctrl_pkg.sv
// Shared types and constants for the data-memory MSHR controller.
//   bus_cmd_e    : memory bus command encoding (BUS_NONE / BUS_LOAD / BUS_STORE)
//   MEM_SIZE     : bus transfer size (BYTE / HALF / WORD / DOUBLE)
//   mshr_entry_t : per-entry status (valid, squashed, memory transaction tag)
//   BLK_OFF_W    : byte-offset width of an 8-byte block
package dmem_mshr_ctrl_pkg;

   localparam int BLK_OFF_W = 3;
   localparam int MEM_TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_cmd_e;

   typedef logic [1:0] MEM_SIZE;
   localparam MEM_SIZE BYTE   = 2'h0;
   localparam MEM_SIZE HALF   = 2'h1;
   localparam MEM_SIZE WORD   = 2'h2;
   localparam MEM_SIZE DOUBLE = 2'h3;

   // Block address and LSQ mask live in parameterised arrays in the top,
   // so only the width-independent status fields are kept here.
   typedef struct packed {
      logic                 valid;
      logic                 squashed;
      logic [MEM_TAG_W-1:0] mem_tag;
   } mshr_entry_t;

endpackage

// File: rtl/dmem_mshr_ctrl_free_sel.sv
// Lowest-free-index priority encoder over the MSHR busy bits.
//   busy     in  N      entry occupied (returning entries still count as busy)
//   free_idx out SEL_W  lowest index with busy=0 (0 when none free)
//   any_free out 1      at least one entry free
//   full     out 1      every entry busy
module dmem_mshr_ctrl_free_sel #(
   parameter  int N     = 4,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     busy,
   output logic [SEL_W-1:0] free_idx,
   output logic             any_free,
   output logic             full
);

   always_comb begin
      free_idx = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (!busy[i]) free_idx = SEL_W'(i);
      end
   end

   assign full     = &busy;
   assign any_free = ~full;

endmodule

// File: rtl/dmem_mshr_ctrl.sv
// Data-memory controller with N_MSHR outstanding read misses.
// Arbitrates writebacks (wb) > write-miss stores (wr) > read misses (rd) onto
// the single memory bus, tracks in-flight loads by memory tag, and on return
// refills the dcache and hands the line plus LSQ grant mask back to the LSQ.
// Build option: DMEM_MSHR_MERGE_EN merges a read miss into a live entry that
// already targets the same block instead of issuing a second BUS_LOAD.
// Ports:
//   clock, reset_n                     clock, async active-low reset
//   except                             pipeline flush (squashes load feedback)
//   wb_valid/wb_ready/wb_addr/wb_data  dirty-line writeback
//   wr_valid/wr_ready/wr_addr/wr_data/wr_size  write-miss store
//   rd_valid/rd_ready/rd_addr/rd_gnt   read miss + LSQ requester mask
//   mem2proc_response/data/tag         memory accept tag, return data, return tag
//   Dmem_command/addr/size/data        bus request (data carries wb/wr payload)
//   mem_feedback, mem_data             LSQ wakeup mask and returned line
//   mem_wr_en/idx/tag/data             dcache refill
//   mshr_full                          all entries occupied
module dmem_mshr_ctrl
   import dmem_mshr_ctrl_pkg::*;
#(
   parameter int N_MSHR = 4,
   parameter int LSQSZ  = 16,
   parameter int ADDR_W = 16,
   parameter int IDX_W  = 5,
   localparam int TAG_W = ADDR_W - IDX_W - BLK_OFF_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              except,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [63:0]       wb_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [63:0]       wr_data,
   input  MEM_SIZE           wr_size,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [LSQSZ-1:0]  rd_gnt,
   input  logic [3:0]        mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [3:0]        mem2proc_tag,
   output bus_cmd_e          Dmem_command,
   output logic [ADDR_W-1:0] Dmem_addr,
   output MEM_SIZE           Dmem_size,
   output logic [63:0]       Dmem_data,
   output logic [LSQSZ-1:0]  mem_feedback,
   output logic [63:0]       mem_data,
   output logic              mem_wr_en,
   output logic [IDX_W-1:0]  mem_wr_idx,
   output logic [TAG_W-1:0]  mem_wr_tag,
   output logic [63:0]       mem_wr_data,
   output logic              mshr_full
);

   localparam int BLK_W = ADDR_W - BLK_OFF_W;
   localparam int SEL_W = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

   mshr_entry_t        ent_q  [N_MSHR];
   logic [BLK_W-1:0]   blk_q  [N_MSHR];
   logic [LSQSZ-1:0]   mask_q [N_MSHR];

   logic [N_MSHR-1:0]  busy, ret_hit, merge_hit;
   logic [SEL_W-1:0]   free_idx, ret_idx;
   logic               any_free, ret_any, accepted, rd_merge, rd_alloc;
   logic [BLK_W-1:0]   rd_blk;
   logic               unused_addr_lsbs;

   assign rd_blk           = rd_addr[ADDR_W-1:BLK_OFF_W];
   assign accepted         = (mem2proc_response != 4'h0);
   assign unused_addr_lsbs = ^{wb_addr[BLK_OFF_W-1:0], rd_addr[BLK_OFF_W-1:0]};

   dmem_mshr_ctrl_free_sel #(.N(N_MSHR)) u_free_sel (
      .busy     (busy),
      .free_idx (free_idx),
      .any_free (any_free),
      .full     (mshr_full)
   );

   always_comb begin
      busy      = '0;
      ret_hit   = '0;
      merge_hit = '0;
      ret_idx   = '0;
      for (int i = 0; i < N_MSHR; i++) begin
         busy[i]    = ent_q[i].valid;
         ret_hit[i] = ent_q[i].valid && (mem2proc_tag != 4'h0) &&
                      (ent_q[i].mem_tag == mem2proc_tag);
         if (ret_hit[i]) ret_idx = SEL_W'(i);
`ifdef DMEM_MSHR_MERGE_EN
         // A returning entry is excluded: its mask is consumed this cycle.
         merge_hit[i] = ent_q[i].valid && !ent_q[i].squashed && !ret_hit[i] &&
                        (blk_q[i] == rd_blk);
`endif
      end
      ret_any = |ret_hit;
   end

   // Entries are cleared asynchronously, so no hit is possible during reset.
   assign mem_wr_en    = ret_any;
   assign mem_wr_idx   = ret_any ? blk_q[ret_idx][IDX_W-1:0] : '0;
   assign mem_wr_tag   = ret_any ? blk_q[ret_idx][BLK_W-1:IDX_W] : '0;
   assign mem_wr_data  = ret_any ? mem2proc_data : '0;
   assign mem_data     = ret_any ? mem2proc_data : '0;
   assign mem_feedback = (ret_any && !ent_q[ret_idx].squashed && !except) ?
                         mask_q[ret_idx] : '0;

   // Issue is gated by reset_n so every output reads 0 while reset is held.
   always_comb begin
      Dmem_command = BUS_NONE;
      Dmem_addr    = '0;
      Dmem_size    = BYTE;
      Dmem_data    = '0;
      wb_ready     = 1'b0;
      wr_ready     = 1'b0;
      rd_ready     = 1'b0;
      rd_alloc     = 1'b0;
      rd_merge     = reset_n && rd_valid && !except && (|merge_hit);
      if (reset_n) begin
         if (wb_valid) begin
            Dmem_command = BUS_STORE;
            Dmem_addr    = {wb_addr[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
            Dmem_size    = DOUBLE;
            Dmem_data    = wb_data;
            wb_ready     = accepted;
         end else if (wr_valid) begin
            Dmem_command = BUS_STORE;
            Dmem_addr    = wr_addr;
            Dmem_size    = wr_size;
            Dmem_data    = wr_data;
            wr_ready     = accepted;
         end else if (rd_valid && !except && !rd_merge && any_free) begin
            Dmem_command = BUS_LOAD;
            Dmem_addr    = {rd_blk, {BLK_OFF_W{1'b0}}};
            Dmem_size    = DOUBLE;
            rd_ready     = accepted;
            rd_alloc     = accepted;
         end
         if (rd_merge) rd_ready = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_MSHR; i++) begin
            ent_q[i]  <= '0;
            blk_q[i]  <= '0;
            mask_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_MSHR; i++) begin
            if (ret_hit[i]) begin
               ent_q[i].valid <= 1'b0;
            end else if (except && ent_q[i].valid) begin
               ent_q[i].squashed <= 1'b1;
               mask_q[i]         <= '0;
            end else if (rd_merge && merge_hit[i]) begin
               mask_q[i] <= mask_q[i] | rd_gnt;
            end
            // Only free entries are allocated, so this never collides with the above.
            if (rd_alloc && (free_idx == SEL_W'(i))) begin
               ent_q[i].valid    <= 1'b1;
               ent_q[i].squashed <= 1'b0;
               ent_q[i].mem_tag  <= mem2proc_response;
               blk_q[i]          <= rd_blk;
               mask_q[i]         <= rd_gnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_mshr_ctrl.sv
// Scoreboard bench for dmem_mshr_ctrl: stimulus pushes expected bus requests
// and refill returns into queues; a negedge monitor pops and compares them.
module tb_dmem_mshr_ctrl;
   import dmem_mshr_ctrl_pkg::*;

   localparam int N_MSHR = 4;
   localparam int LSQSZ  = 16;
   localparam int ADDR_W = 16;
   localparam int IDX_W  = 5;
   localparam int TAG_W  = ADDR_W - IDX_W - 3;
   localparam logic [2:0] RDY_WB = 3'b100, RDY_WR = 3'b010, RDY_RD = 3'b001;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              except;
   logic              wb_valid, wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [63:0]       wb_data;
   logic              wr_valid, wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [63:0]       wr_data;
   logic [1:0]        wr_size;
   logic              rd_valid, rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [LSQSZ-1:0]  rd_gnt;
   logic [3:0]        mem2proc_response, mem2proc_tag;
   logic [63:0]       mem2proc_data;
   bus_cmd_e          Dmem_command;
   logic [ADDR_W-1:0] Dmem_addr;
   logic [1:0]        Dmem_size;
   logic [63:0]       Dmem_data;
   logic [LSQSZ-1:0]  mem_feedback;
   logic [63:0]       mem_data;
   logic              mem_wr_en;
   logic [IDX_W-1:0]  mem_wr_idx;
   logic [TAG_W-1:0]  mem_wr_tag;
   logic [63:0]       mem_wr_data;
   logic              mshr_full;

   dmem_mshr_ctrl #(.N_MSHR(N_MSHR), .LSQSZ(LSQSZ), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
      .clock(clock), .reset_n(reset_n), .except(except),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_size(wr_size),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag),
      .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_size(Dmem_size),
      .Dmem_data(Dmem_data),
      .mem_feedback(mem_feedback), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
      .mem_wr_idx(mem_wr_idx), .mem_wr_tag(mem_wr_tag), .mem_wr_data(mem_wr_data),
      .mshr_full(mshr_full)
   );

   always #5 clock = ~clock;

   typedef struct {
      string             name;
      logic [1:0]        cmd;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        size;
      logic [63:0]       data;
      logic [2:0]        rdy;
   } bus_exp_t;

   typedef struct {
      string             name;
      logic [IDX_W-1:0]  idx;
      logic [TAG_W-1:0]  tag;
      logic [LSQSZ-1:0]  fb;
      logic [63:0]       data;
   } ret_exp_t;

   bus_exp_t bus_q[$];
   ret_exp_t ret_q[$];
   bus_exp_t be;
   ret_exp_t re;
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_bus(input string n, input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                          input logic [1:0] size, input logic [63:0] data, input logic [2:0] rdy);
      bus_exp_t e;
      e.name = n; e.cmd = cmd; e.addr = addr; e.size = size; e.data = data; e.rdy = rdy;
      bus_q.push_back(e);
   endtask

   task automatic exp_ret(input string n, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [LSQSZ-1:0] fb, input logic [63:0] data);
      ret_exp_t e;
      e.name = n; e.idx = idx; e.tag = tag; e.fb = fb; e.data = data;
      ret_q.push_back(e);
   endtask

   // Monitor: every bus command and every refill must match the next expectation.
   always @(negedge clock) begin
      if (reset_n) begin
         if (Dmem_command != BUS_NONE) begin
            if (bus_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_bus: got cmd %0d addr 0x%0h, expected no command",
                        Dmem_command, Dmem_addr);
            end else begin
               be = bus_q.pop_front();
               check({be.name, "_cmd"},  64'(Dmem_command), 64'(be.cmd));
               check({be.name, "_addr"}, 64'(Dmem_addr), 64'(be.addr));
               check({be.name, "_size"}, 64'(Dmem_size), 64'(be.size));
               check({be.name, "_data"}, Dmem_data, be.data);
               check({be.name, "_rdy"},  64'({wb_ready, wr_ready, rd_ready}), 64'(be.rdy));
            end
         end
         if (mem_wr_en) begin
            if (ret_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_refill: got idx 0x%0h tag 0x%0h, expected no refill",
                        mem_wr_idx, mem_wr_tag);
            end else begin
               re = ret_q.pop_front();
               check({re.name, "_idx"},   64'(mem_wr_idx), 64'(re.idx));
               check({re.name, "_tag"},   64'(mem_wr_tag), 64'(re.tag));
               check({re.name, "_fb"},    64'(mem_feedback), 64'(re.fb));
               check({re.name, "_wdata"}, mem_wr_data, re.data);
               check({re.name, "_mdata"}, mem_data, re.data);
            end
         end
      end
   end

   task automatic idle();
      except = 0; wb_valid = 0; wb_addr = '0; wb_data = '0;
      wr_valid = 0; wr_addr = '0; wr_data = '0; wr_size = BYTE;
      rd_valid = 0; rd_addr = '0; rd_gnt = '0;
      mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [LSQSZ-1:0] g, input logic [3:0] resp);
      rd_valid = 1; rd_addr = a; rd_gnt = g; mem2proc_response = resp;
   endtask

   task automatic ret(input logic [3:0] t, input logic [63:0] d);
      mem2proc_tag = t; mem2proc_data = d;
   endtask

   task automatic check_all_zero(input string n);
      check({n, "_cmd"},   64'(Dmem_command), 64'(BUS_NONE));
      check({n, "_addr"},  64'(Dmem_addr), 64'h0);
      check({n, "_rdy"},   64'({wb_ready, wr_ready, rd_ready}), 64'h0);
      check({n, "_wr_en"}, 64'(mem_wr_en), 64'h0);
      check({n, "_fb"},    64'(mem_feedback), 64'h0);
      check({n, "_mdata"}, mem_data, 64'h0);
      check({n, "_full"},  64'(mshr_full), 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      repeat (3) cyc();
      check_all_zero("reset");
      reset_n = 1;
      cyc();

      // Single read miss and return
      rd(16'h0120, 16'h0004, 4'd3);
      exp_bus("t2_ld", BUS_LOAD, 16'h0120, DOUBLE, 64'h0, RDY_RD);
      cyc();
      idle(); #1;
      check("t2_full", 64'(mshr_full), 64'h0);
      cyc();
      ret(4'd3, 64'hDEAD_BEEF_0123_4567);
      exp_ret("t2_ret", 5'h04, 8'h01, 16'h0004, 64'hDEAD_BEEF_0123_4567);
      cyc();
      idle(); cyc();

      // Priority wb > wr > rd
      wb_valid = 1; wb_addr = 16'h0345; wb_data = 64'h1111_2222_3333_4444;
      wr_valid = 1; wr_addr = 16'h0456; wr_data = 64'h5555_6666_7777_8888; wr_size = WORD;
      rd(16'h0563, 16'h0002, 4'd5);
      exp_bus("t3_wb", BUS_STORE, 16'h0340, DOUBLE, 64'h1111_2222_3333_4444, RDY_WB);
      cyc();
      wb_valid = 0;
      exp_bus("t3_wr", BUS_STORE, 16'h0456, WORD, 64'h5555_6666_7777_8888, RDY_WR);
      cyc();
      wr_valid = 0; mem2proc_response = 4'd6;
      exp_bus("t3_rd", BUS_LOAD, 16'h0560, DOUBLE, 64'h0, RDY_RD);
      cyc();
      idle();
      ret(4'd6, 64'hA5A5_0000_FFFF_1234);
      exp_ret("t3_ret", 5'h0C, 8'h05, 16'h0002, 64'hA5A5_0000_FFFF_1234);
      cyc();
      idle(); cyc();

      // Fill all entries, stall, free one, reuse
      for (int k = 0; k < 4; k++) begin
         rd(16'h1000 + 16'(8*k), 16'(1 << k), 4'(k + 1));
         exp_bus("t4_fill", BUS_LOAD, 16'h1000 + 16'(8*k), DOUBLE, 64'h0, RDY_RD);
         cyc();
      end
      idle(); #1;
      check("t4_full", 64'(mshr_full), 64'h1);
      rd(16'h1020, 16'h0010, 4'd7); #1;
      check("t4_stall_rdy", 64'(rd_ready), 64'h0);
      check("t4_stall_cmd", 64'(Dmem_command), 64'(BUS_NONE));
      cyc();
      wr_valid = 1; wr_addr = 16'h2001; wr_data = 64'h99; wr_size = BYTE;
      exp_bus("t4_wr", BUS_STORE, 16'h2001, BYTE, 64'h99, RDY_WR);
      cyc();
      wr_valid = 0;
      ret(4'd2, 64'h0000_0000_0000_0B0B);
      exp_ret("t4_ret2", 5'h01, 8'h10, 16'h0002, 64'h0000_0000_0000_0B0B);
      #1;
      check("t4_ret_rdy", 64'(rd_ready), 64'h0);
      check("t4_ret_full", 64'(mshr_full), 64'h1);
      cyc();
      ret(4'd0, 64'h0); mem2proc_response = 4'd2;
      exp_bus("t4_reuse", BUS_LOAD, 16'h1020, DOUBLE, 64'h0, RDY_RD);
      cyc();
      idle(); #1;
      check("t4_full_again", 64'(mshr_full), 64'h1);
      ret(4'd3, 64'h3333);
      exp_ret("t4_ret3", 5'h02, 8'h10, 16'h0004, 64'h3333);
      cyc();
      ret(4'd4, 64'h4444);
      exp_ret("t4_ret4", 5'h03, 8'h10, 16'h0008, 64'h4444);
      cyc();
      idle(); #1;
      check("t4_not_full", 64'(mshr_full), 64'h0);
      cyc();

      // Flush with tags 1 and 2 live
      except = 1;
      rd(16'h3000, 16'h0020, 4'd8); #1;
      check("t5_rd_rdy", 64'(rd_ready), 64'h0);
      check("t5_rd_cmd", 64'(Dmem_command), 64'(BUS_NONE));
      cyc();
      rd_valid = 0;
      wb_valid = 1; wb_addr = 16'h0808; wb_data = 64'hCAFE; mem2proc_response = 4'd9;
      exp_bus("t5_wb", BUS_STORE, 16'h0808, DOUBLE, 64'hCAFE, RDY_WB);
      cyc();
      idle();
      ret(4'd1, 64'h5151);
      exp_ret("t5_ret1", 5'h00, 8'h10, 16'h0000, 64'h5151);
      cyc();
      ret(4'd2, 64'h5252);
      exp_ret("t5_ret2", 5'h04, 8'h10, 16'h0000, 64'h5252);
      cyc();
      idle();
      rd(16'h0128, 16'h0040, 4'd9);
      exp_bus("t5_ld", BUS_LOAD, 16'h0128, DOUBLE, 64'h0, RDY_RD);
      cyc();
      idle();
      except = 1;
      ret(4'd9, 64'h5959);
      exp_ret("t5_retx", 5'h05, 8'h01, 16'h0000, 64'h5959);
      cyc();
      idle(); cyc();

      // Same-block read misses
      rd(16'h0120, 16'h0001, 4'd12);
      exp_bus("t6_ld1", BUS_LOAD, 16'h0120, DOUBLE, 64'h0, RDY_RD);
      cyc();
      rd(16'h0124, 16'h0010, 4'd13);
`ifdef DMEM_MSHR_MERGE_EN
      #1;
      check("t6_merge_rdy", 64'(rd_ready), 64'h1);
      check("t6_merge_cmd", 64'(Dmem_command), 64'(BUS_NONE));
      cyc();
      idle();
      ret(4'd12, 64'h6666);
      exp_ret("t6_ret", 5'h04, 8'h01, 16'h0011, 64'h6666);
      cyc();
`else
      exp_bus("t6_ld2", BUS_LOAD, 16'h0120, DOUBLE, 64'h0, RDY_RD);
      cyc();
      idle();
      ret(4'd12, 64'h6666);
      exp_ret("t6_ret1", 5'h04, 8'h01, 16'h0001, 64'h6666);
      cyc();
      ret(4'd13, 64'h6767);
      exp_ret("t6_ret2", 5'h04, 8'h01, 16'h0010, 64'h6767);
      cyc();
`endif
      idle(); cyc();

      // Reset mid-traffic
      rd(16'h0200, 16'h0001, 4'd10);
      exp_bus("t1_ld1", BUS_LOAD, 16'h0200, DOUBLE, 64'h0, RDY_RD);
      cyc();
      rd(16'h0208, 16'h0002, 4'd11);
      exp_bus("t1_ld2", BUS_LOAD, 16'h0208, DOUBLE, 64'h0, RDY_RD);
      cyc();
      idle();
      wb_valid = 1; wb_addr = 16'h0500; mem2proc_response = 4'd1;
      ret(4'd10, 64'h1010);
      reset_n = 0;
      #1;
      check_all_zero("t1_in_reset");
      cyc();
      idle();
      reset_n = 1;
      cyc();
      ret(4'd10, 64'h1010); #1;
      check("t1_stale10_en", 64'(mem_wr_en), 64'h0);
      check("t1_stale10_fb", 64'(mem_feedback), 64'h0);
      cyc();
      ret(4'd11, 64'h1111); #1;
      check("t1_stale11_en", 64'(mem_wr_en), 64'h0);
      cyc();
      idle(); cyc(); cyc();

      check("bus_q_drained", 64'(bus_q.size()), 64'h0);
      check("ret_q_drained", 64'(ret_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
